// File: rtl/encrypt_ofb_stream.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_ofb_stream
// Description : AES-128 OFB stream encryptor driving an external AES core
//               through a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module encrypt_ofb_stream #(
    parameter int AES_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [127:0]     key,
    input  logic [127:0]     iv,
    input  logic             pt_valid,
    output logic             pt_ready,
    input  logic [127:0]     pt,
    input  logic             pt_last,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic [127:0]     ct,
    output logic             ct_last,
    output logic             aes_start,
    output logic [127:0]     aes_key,
    output logic [127:0]     aes_in,
    input  logic             aes_done,
    input  logic [127:0]     aes_out,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_GEN   = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_READY = 3'd3;
    localparam logic [2:0] c_ST_OUT   = 3'd4;
    localparam logic [2:0] c_ST_FLUSH = 3'd5;

    localparam int              c_TO_W    = $clog2(AES_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(AES_TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [127:0]      r_fb;
    logic [127:0]      r_key;
    logic [127:0]      r_ks;
    logic [127:0]      r_ct;
    logic              r_ct_valid;
    logic              r_ct_last;
    logic              r_done;
    logic              r_err;
    logic [CNT_W-1:0]  r_blk_cnt;
    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_fb       <= '0;
            r_key      <= '0;
            r_ks       <= '0;
            r_ct       <= '0;
            r_ct_valid <= 1'b0;
            r_ct_last  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_blk_cnt  <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            if (ld) begin
                // A result still owed by the core must be drained before reuse
                r_fb       <= iv;
                r_key      <= key;
                r_blk_cnt  <= '0;
                r_err      <= 1'b0;
                r_ct_valid <= 1'b0;
                r_ct_last  <= 1'b0;
                r_to_cnt   <= '0;
                r_state    <= (r_state == c_ST_WAIT || r_state == c_ST_FLUSH)
                              ? c_ST_FLUSH : c_ST_GEN;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_state <= c_ST_IDLE;
                    end
                    c_ST_GEN: begin
                        r_to_cnt <= '0;
                        r_state  <= c_ST_WAIT;
                    end
                    c_ST_WAIT: begin
                        if (aes_done) begin
                            r_ks    <= aes_out;
                            r_fb    <= aes_out;
                            r_state <= c_ST_READY;
                        end else if (r_to_cnt == c_TO_LAST) begin
                            r_err   <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_TO_W'(1);
                        end
                    end
                    c_ST_FLUSH: begin
                        if (aes_done) begin
                            r_state <= c_ST_GEN;
                        end else if (r_to_cnt == c_TO_LAST) begin
                            r_err   <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_TO_W'(1);
                        end
                    end
                    c_ST_READY: begin
                        if (pt_valid) begin
                            r_ct       <= pt ^ r_ks;
                            r_ct_last  <= pt_last;
                            r_ct_valid <= 1'b1;
                            r_state    <= c_ST_OUT;
                        end
                    end
                    c_ST_OUT: begin
                        if (r_ct_valid && ct_ready) begin
                            r_ct_valid <= 1'b0;
                            r_ct_last  <= 1'b0;
                            r_blk_cnt  <= r_blk_cnt + CNT_W'(1);
                            if (r_ct_last) begin
                                r_done  <= 1'b1;
                                r_state <= c_ST_IDLE;
                            end else begin
                                r_state <= c_ST_GEN;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign pt_ready  = (r_state == c_ST_READY);
    assign aes_start = (r_state == c_ST_GEN);
    assign busy      = (r_state != c_ST_IDLE);
    assign aes_key   = r_key;
    assign aes_in    = r_fb;
    assign ct        = r_ct;
    assign ct_valid  = r_ct_valid;
    assign ct_last   = r_ct_last;
    assign done      = r_done;
    assign err       = r_err;
    assign blk_cnt   = r_blk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_encrypt_ofb_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_encrypt_ofb_stream
// Description : Directed self-checking bench for encrypt_ofb_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encrypt_ofb_stream;

    localparam int c_TIMEOUT = 64;
    localparam int c_AES_LAT = 10;

    localparam logic [127:0] c_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_IV  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] c_P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] c_P3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] c_O1  = 128'h50fe67cc996d32b6da0937e99bafec60;
    localparam logic [127:0] c_O2  = 128'hd9a4dada0892239f6b8b3d7680e15674;
    localparam logic [127:0] c_C1  = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
    localparam logic [127:0] c_C2  = 128'h7789508d16918f03f53c52dac54ed825;

    logic         clk = 1'b0;
    logic         rst, ld, pt_valid, pt_last, ct_ready, aes_done;
    logic [127:0] key, iv, pt, aes_out;
    logic         pt_ready, ct_valid, ct_last, aes_start, done, busy, err;
    logic [127:0] ct, aes_key, aes_in;
    logic [15:0]  blk_cnt;

    logic model_en  = 1'b1;
    logic inj_pulse = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    encrypt_ofb_stream #(.AES_TIMEOUT(c_TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ld(ld), .key(key), .iv(iv),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt(pt), .pt_last(pt_last),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct(ct), .ct_last(ct_last),
        .aes_start(aes_start), .aes_key(aes_key), .aes_in(aes_in),
        .aes_done(aes_done), .aes_out(aes_out),
        .done(done), .busy(busy), .err(err), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    // Known NIST OFB outputs for the test key; anything else gets a stand-in mix
    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] x);
        if (k == c_KEY && x == c_IV) return c_O1;
        if (k == c_KEY && x == c_O1) return c_O2;
        return {x[94:0], x[127:95]} ^ {k[63:0], k[127:64]} ^ 128'h5a5a_3c3c_a5a5_c3c3_0f0f_f0f0_1234_5678;
    endfunction

    initial begin
        aes_done = 1'b0;
        aes_out  = '0;
        forever begin
            @(negedge clk);
            if (aes_start && model_en) begin
                logic [127:0] res;
                res = aes_model(aes_key, aes_in);
                repeat (c_AES_LAT) @(posedge clk);
                #1;
                aes_done = 1'b1;
                aes_out  = res;
                @(posedge clk);
                #1;
                aes_done = 1'b0;
                aes_out  = '0;
            end else if (inj_pulse) begin
                aes_done = 1'b1;
                aes_out  = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
                @(negedge clk);
                aes_done = 1'b0;
                aes_out  = '0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // sel: 0 aes_start, 1 pt_ready
    task automatic wait_for(input int sel, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ((sel == 0) ? aes_start : pt_ready) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, "_wait"}, 128'(hit), 128'd1);
    endtask

    task automatic start_session(input logic [127:0] k, input logic [127:0] v);
        key = k;
        iv  = v;
        ld  = 1'b1;
        @(negedge clk);
        ld  = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] p, input logic last, input string tag);
        wait_for(1, tag);
        pt       = p;
        pt_last  = last;
        pt_valid = 1'b1;
        @(negedge clk);
        pt_valid = 1'b0;
        pt_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bad;
        int   n;
        logic saw_ready;
        logic hit;
        rst = 1'b1; ld = 1'b0; key = '0; iv = '0;
        pt_valid = 1'b0; pt = '0; pt_last = 1'b0; ct_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_flags", {pt_ready, ct_valid, ct_last, aes_start, done, busy, err}, 7'd0);
        check_eq("reset_blk_cnt", blk_cnt, 0);

        // Single NIST block
        start_session(c_KEY, c_IV);
        check_eq("t1_start", aes_start, 1);
        check_eq("t1_aes_in", aes_in, c_IV);
        check_eq("t1_aes_key", aes_key, c_KEY);
        send_block(c_P1, 1'b1, "t1");
        check_eq("t1_ct_valid", ct_valid, 1);
        check_eq("t1_ct", ct, c_C1);
        check_eq("t1_ct_last", ct_last, 1);
        @(negedge clk);
        check_eq("t1_done", {done, ct_valid}, 2'b10);
        check_eq("t1_blk_cnt", blk_cnt, 1);
        @(negedge clk);
        check_eq("t1_done_once", {done, busy}, 2'b00);

        // Two blocks chained through the feedback register
        start_session(c_KEY, c_IV);
        send_block(c_P1, 1'b0, "t2a");
        check_eq("t2_ct1", ct, c_C1);
        check_eq("t2_ct1_last", ct_last, 0);
        @(negedge clk);
        wait_for(0, "t2_gen");
        check_eq("t2_aes_in2", aes_in, c_O1);
        check_eq("t2_blk_cnt1", blk_cnt, 1);
        send_block(c_P2, 1'b1, "t2b");
        check_eq("t2_ct2", ct, c_C2);
        check_eq("t2_ct2_last", ct_last, 1);
        @(negedge clk);
        check_eq("t2_done", done, 1);
        check_eq("t2_blk_cnt2", blk_cnt, 2);

        // Output backpressure
        start_session(c_KEY, c_IV);
        ct_ready = 1'b0;
        send_block(c_P1, 1'b1, "t3");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (ct !== c_C1 || ct_valid !== 1'b1 || ct_last !== 1'b1 ||
                pt_ready !== 1'b0 || aes_start !== 1'b0 || blk_cnt !== 16'd0)
                bad++;
            @(negedge clk);
        end
        check_eq("t3_stable", bad, 0);
        ct_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_handshake", {blk_cnt, done, ct_valid}, {16'd1, 2'b10});

        // Reload while the core still owes a result
        start_session(c_KEY, c_IV);
        repeat (3) @(negedge clk);
        start_session(c_KEY, 128'd0);
        check_eq("t4_flush_state", {busy, aes_start, pt_ready}, 3'b100);
        saw_ready = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            saw_ready |= pt_ready;
            if (aes_start) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("t4_restart", hit, 1);
        check_eq("t4_stale_dropped", saw_ready, 0);
        check_eq("t4_aes_in", aes_in, 128'd0);
        send_block(c_P3, 1'b1, "t4");
        check_eq("t4_ct", ct, c_P3 ^ aes_model(c_KEY, 128'd0));
        @(negedge clk);
        check_eq("t4_done", {blk_cnt, done}, {16'd1, 1'b1});

        // AES core never answers
        model_en = 1'b0;
        start_session(c_KEY, c_IV);
        check_eq("t5_start", aes_start, 1);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (err) begin
                n = i;
                break;
            end
        end
        check_eq("t5_err_cycle", n, c_TIMEOUT + 1);
        @(negedge clk);
        check_eq("t5_idle", {busy, pt_ready, err}, 3'b001);
        model_en = 1'b1;
        start_session(c_KEY, c_IV);
        check_eq("t5_err_cleared", err, 0);

        // Reset while holding a ciphertext; ld in the same cycle must lose
        ct_ready = 1'b0;
        send_block(c_P1, 1'b1, "t6");
        check_eq("t6_pre_valid", ct_valid, 1);
        rst = 1'b1;
        ld  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ld  = 1'b0;
        check_eq("t6_flags", {pt_ready, ct_valid, ct_last, aes_start, done, busy, err}, 7'd0);
        check_eq("t6_blk_cnt", blk_cnt, 0);
        check_eq("t6_ct", ct, 128'd0);
        check_eq("t6_aes_in", aes_in, 128'd0);
        ct_ready  = 1'b1;
        inj_pulse = 1'b1;
        repeat (4) @(negedge clk);
        inj_pulse = 1'b0;
        @(negedge clk);
        check_eq("t6_done_ignored", {busy, pt_ready, ct_valid}, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
